gpio_cfg_shift_stage: RTL and testbench

//  Per-pad GPIO configuration stage; consumes the buffered one/zero constants, which arrive as the gpio_defaults bus.

---
 rtl/gpio_cfg_pkg.sv | 25 ++
 rtl/gpio_cfg_shreg.sv | 47 ++++
 rtl/gpio_cfg_shift_stage.sv | 83 ++++++++
 tb/tb_gpio_cfg_shift_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the per-pad GPIO configuration stage: word width, field positions
// and the management-mode reset default.
package gpio_cfg_pkg;

    localparam int unsigned CFG_W = 13;
    localparam int unsigned CNT_W = 4;

    localparam int unsigned CFG_MGMT_ENA = 0;
    localparam int unsigned CFG_OUT_DIS  = 1;
    localparam int unsigned CFG_HOLD_OVR = 2;
    localparam int unsigned CFG_INP_DIS  = 3;
    localparam int unsigned CFG_IB_MODE  = 4;
    localparam int unsigned CFG_ANA_EN   = 5;
    localparam int unsigned CFG_ANA_SEL  = 6;
    localparam int unsigned CFG_ANA_POL  = 7;
    localparam int unsigned CFG_SLOW     = 8;
    localparam int unsigned CFG_VTRIP    = 9;
    localparam int unsigned CFG_DM_LSB   = 10;
    localparam int unsigned CFG_DM_MSB   = 12;

    localparam logic [CFG_W-1:0] GPIO_DEFAULT_MGMT_IN = 13'h0403;

    typedef logic [CFG_W-1:0] cfg_word_t;

endpackage

// File: rtl/gpio_cfg_shreg.sv
// Serial configuration shift register with a saturating count of bits received since the
// last load strobe; frame_full means a complete word is sitting in the register.
module gpio_cfg_shreg
    import gpio_cfg_pkg::*;
(
    input  logic             serial_clock,
    input  logic             resetn,
    input  logic [CFG_W-1:0] gpio_defaults,
    input  logic             serial_data_in,
    input  logic             serial_load,
    output logic [CFG_W-1:0] shift_reg,
    output logic             frame_full
);

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            shift_q <= gpio_defaults;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load strobe freezes the register and restarts the frame count.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (serial_load) begin
            cnt_d = '0;
        end else begin
            shift_d = {shift_q[CFG_W-2:0], serial_data_in};
            if (cnt_q != CntFull) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign shift_reg  = shift_q;
    assign frame_full = (cnt_q == CntFull);

endmodule

// File: rtl/gpio_cfg_shift_stage.sv
// One pad's configuration stage: daisy-chained serial shift path, committed config word with
// frame checking, and the management/user pad output mux.
module gpio_cfg_shift_stage
    import gpio_cfg_pkg::*;
(
    input  logic             serial_clock,
    input  logic             resetn,
    input  logic [CFG_W-1:0] gpio_defaults,
    input  logic             serial_data_in,
    input  logic             serial_load,
    output logic             serial_data_out,
    output logic [CFG_W-1:0] cfg,
    output logic             load_done,
    output logic             frame_err,
    input  logic             mgmt_gpio_out,
    input  logic             user_gpio_out,
    input  logic             user_gpio_oeb,
    output logic             pad_gpio_out,
    output logic             pad_gpio_oeb
);

    cfg_word_t shift_reg;
    logic      frame_full;

    cfg_word_t cfg_q, cfg_d;
    logic      load_done_q, load_done_d;
    logic      frame_err_q, frame_err_d;

    gpio_cfg_shreg u_shreg (
        .serial_clock   (serial_clock),
        .resetn         (resetn),
        .gpio_defaults  (gpio_defaults),
        .serial_data_in (serial_data_in),
        .serial_load    (serial_load),
        .shift_reg      (shift_reg),
        .frame_full     (frame_full)
    );

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            cfg_q       <= gpio_defaults;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Only a strobe arriving on a complete frame commits; anything shorter is flagged and
    // the error stays set until the next good commit.
    always_comb begin
        cfg_d       = cfg_q;
        load_done_d = 1'b0;
        frame_err_d = frame_err_q;
        if (serial_load) begin
            if (frame_full) begin
                cfg_d       = shift_reg;
                load_done_d = 1'b1;
                frame_err_d = 1'b0;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (cfg_q[CFG_MGMT_ENA]) begin
            pad_gpio_out = mgmt_gpio_out;
            pad_gpio_oeb = cfg_q[CFG_OUT_DIS];
        end else begin
            pad_gpio_out = user_gpio_out;
            pad_gpio_oeb = user_gpio_oeb;
        end
    end

    assign serial_data_out = shift_reg[CFG_W-1];
    assign cfg             = cfg_q;
    assign load_done       = load_done_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_gpio_cfg_shift_stage.sv
// Two chained configuration stages driven by directed serial frames; expected results are
// queued at stimulus time and checked by an independent monitor.
module tb_gpio_cfg_shift_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sdi = 1'b0;
    logic        sload = 1'b0;
    logic        mgmt_out = 1'b0;
    logic        user_out = 1'b1;
    logic        user_oeb = 1'b0;
    logic [12:0] defaults = 13'h0403;

    logic        sdo0, sdo1;
    logic [12:0] cfg0, cfg1;
    logic        done0, done1, err0, err1;
    logic        pout0, poeb0, pout1, poeb1;

    always #5 clk = ~clk;

    gpio_cfg_shift_stage dut0 (
        .serial_clock    (clk),
        .resetn          (resetn),
        .gpio_defaults   (defaults),
        .serial_data_in  (sdi),
        .serial_load     (sload),
        .serial_data_out (sdo0),
        .cfg             (cfg0),
        .load_done       (done0),
        .frame_err       (err0),
        .mgmt_gpio_out   (mgmt_out),
        .user_gpio_out   (user_out),
        .user_gpio_oeb   (user_oeb),
        .pad_gpio_out    (pout0),
        .pad_gpio_oeb    (poeb0)
    );

    gpio_cfg_shift_stage dut1 (
        .serial_clock    (clk),
        .resetn          (resetn),
        .gpio_defaults   (defaults),
        .serial_data_in  (sdo0),
        .serial_load     (sload),
        .serial_data_out (sdo1),
        .cfg             (cfg1),
        .load_done       (done1),
        .frame_err       (err1),
        .mgmt_gpio_out   (mgmt_out),
        .user_gpio_out   (user_out),
        .user_gpio_oeb   (user_oeb),
        .pad_gpio_out    (pout1),
        .pad_gpio_oeb    (poeb1)
    );

    typedef struct {
        string       name;
        logic [12:0] cfg0;
        logic [12:0] cfg1;
        bit          chk1;
        logic        done;
        logic        err;
        logic        sdo;
        logic        pout;
        logic        poeb;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    logic chk_req = 1'b0;
    logic load_seen = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) load_seen <= 1'b0;
        else         load_seen <= sload;
    end

    task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an observation point is the cycle after a load strobe or an explicit check.
    always @(negedge clk) begin
        if (load_seen || chk_req) begin
            if (sbq.size() == 0) begin
                cmp("scoreboard_underflow", 13'h1, 13'h0);
            end else begin
                e = sbq.pop_front();
                cmp({e.name, ".cfg0"}, cfg0, e.cfg0);
                if (e.chk1) cmp({e.name, ".cfg1"}, cfg1, e.cfg1);
                cmp({e.name, ".load_done"}, {12'b0, done0}, {12'b0, e.done});
                cmp({e.name, ".frame_err"}, {12'b0, err0}, {12'b0, e.err});
                cmp({e.name, ".sdo"}, {12'b0, sdo0}, {12'b0, e.sdo});
                cmp({e.name, ".pad_out"}, {12'b0, pout0}, {12'b0, e.pout});
                cmp({e.name, ".pad_oeb"}, {12'b0, poeb0}, {12'b0, e.poeb});
            end
        end else begin
            cmp("idle.load_done", {12'b0, done0}, 13'h0);
        end
    end

    function automatic exp_t mk(input string name, input logic [12:0] c0, input logic [12:0] c1,
                                input bit chk1, input logic done, input logic err,
                                input logic sdo, input logic pout, input logic poeb);
        exp_t x;
        x.name = name; x.cfg0 = c0; x.cfg1 = c1; x.chk1 = chk1;
        x.done = done; x.err = err; x.sdo = sdo; x.pout = pout; x.poeb = poeb;
        return x;
    endfunction

    task automatic shift_bit(input logic b);
        sdi = b;
        sload = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [12:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_load(input exp_t x, input logic b);
        sbq.push_back(x);
        sdi = b;
        sload = 1'b1;
        @(posedge clk);
        #1;
        sload = 1'b0;
    endtask

    task automatic obs(input exp_t x);
        sbq.push_back(x);
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        int t;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        // Defaults: mgmt_ena=1, out_dis=1 -> pad follows mgmt data, output disabled.
        obs(mk("reset", 13'h0403, 13'h0403, 1, 0, 0, 0, 0, 1));

        shift_word(13'h1803, 13);
        do_load(mk("good_frame", 13'h1803, 13'h0, 0, 1, 0, 1, 0, 1), 1'b0);

        shift_word(13'h0000, 12);
        do_load(mk("short_frame", 13'h1803, 13'h0, 0, 0, 1, 1, 0, 1), 1'b0);

        shift_word(13'h0A54, 13);
        do_load(mk("recover_user", 13'h0A54, 13'h0, 0, 1, 0, 0, 1, 0), 1'b0);

        // Data bit coincident with load must not shift (sdo would become 1 if it did).
        shift_word(13'h1FFF, 5);
        do_load(mk("load_vs_data", 13'h0A54, 13'h0, 0, 0, 1, 0, 1, 0), 1'b1);
        shift_word(13'h0000, 12);
        do_load(mk("cnt_cleared", 13'h0A54, 13'h0, 0, 0, 1, 1, 1, 0), 1'b0);

        shift_word(13'h1234, 13);
        shift_word(13'h0567, 13);
        do_load(mk("chain", 13'h0567, 13'h1234, 1, 1, 0, 0, 0, 1), 1'b0);

        shift_word(13'h1FFF, 7);
        resetn = 1'b0;
        obs(mk("mid_reset", 13'h0403, 13'h0403, 1, 0, 0, 0, 0, 1));
        resetn = 1'b1;
        shift_word(13'h1FFF, 12);
        do_load(mk("post_reset_cnt", 13'h0403, 13'h0403, 1, 0, 1, 1, 0, 1), 1'b0);

        t = 0;
        while (sbq.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        cmp("scoreboard_drain", 13'(sbq.size()), 13'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
